mw_ctrl_pipe: RTL and testbench

MW_CTRL_PIPE -- requirements
Module: mw_ctrl_pipe

---
 rtl/mw_ctrl_pipe.sv | 215 +++++++++++++++++++++
 tb/tb_mw_ctrl_pipe.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mw_ctrl_pipe.sv
// Memory/writeback control stage: captures one instruction, runs the data-cache
// access when needed, then presents registered writeback and CSR-write controls.
module mw_ctrl_pipe #(
   parameter int                    XLEN      = 32,
   parameter int                    NUM_CSR   = 1,
   parameter logic [12*NUM_CSR-1:0] CSR_ADDRS = 12'h51E
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [6:0]              opcode,
   input  logic [2:0]              funct3,
   input  logic [11:0]             csr,
   input  logic [4:0]              rd,
   input  logic [XLEN-1:0]         addr,
   input  logic [XLEN-1:0]         store_data,
   input  logic [XLEN-1:0]         csr_wdata,
   output logic                    dcache_re,
   output logic [3:0]              dcache_we,
   output logic [XLEN-1:0]         dcache_addr,
   output logic [XLEN-1:0]         dcache_din,
   input  logic                    dcache_stall,
   input  logic [XLEN-1:0]         dcache_dout,
   output logic                    wb_valid,
   output logic [1:0]              wb_sel,
   output logic                    rwe,
   output logic [4:0]              wb_rd,
   output logic [XLEN-1:0]         load_data,
   output logic                    misalign,
   output logic [NUM_CSR-1:0]      csr_we,
   output logic [NUM_CSR*XLEN-1:0] csr_q
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MEM  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_CSR    = 7'b1110011;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   localparam logic [1:0] SEL_ALU = 2'b01;
   localparam logic [1:0] SEL_MEM = 2'b10;
   localparam logic [1:0] SEL_PC4 = 2'b11;

   logic [1:0]              r_state;
   logic                    r_is_load;
   logic                    r_is_store;
   logic                    r_mis;
   logic [1:0]              r_wb_sel;
   logic                    r_rwe;
   logic [4:0]              r_rd;
   logic [2:0]              r_funct3;
   logic [XLEN-1:0]         r_addr;
   logic [XLEN-1:0]         r_din;
   logic [3:0]              r_mask;
   logic [XLEN-1:0]         r_csr_wdata;
   logic [NUM_CSR-1:0]      r_csr_hit;
   logic [XLEN-1:0]         r_dout;
   logic [NUM_CSR*XLEN-1:0] r_csr_q;

   logic                    w_capture;
   logic                    w_done;
   logic                    w_is_load;
   logic                    w_is_store;
   logic                    w_mis;
   logic [1:0]              w_wb_sel;
   logic                    w_rwe;
   logic [3:0]              w_mask;
   logic [XLEN-1:0]         w_din;
   logic [NUM_CSR-1:0]      w_csr_hit;
   logic                    w_csr_found;
   logic [7:0]              w_byte;
   logic [15:0]             w_half;
   logic [XLEN-1:0]         w_load;

   assign in_ready  = (r_state == ST_IDLE) || (r_state == ST_DONE);
   assign w_capture = in_valid && in_ready;
   assign w_done    = (r_state == ST_DONE);

   always_comb begin
      w_is_load  = (opcode == OP_LOAD);
      w_is_store = (opcode == OP_STORE);
      w_mis      = (w_is_load || w_is_store) &&
                   (((funct3[1:0] == 2'b01) && addr[0]) ||
                    ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00)));
      w_wb_sel = 2'b00;
      w_rwe    = 1'b0;
      case (opcode)
         OP_CSR:                      w_wb_sel = SEL_ALU;
         OP_AUIPC, OP_LUI,
         OP_RTYPE, OP_ITYPE: begin    w_wb_sel = SEL_ALU; w_rwe = 1'b1; end
         OP_LOAD: begin               w_wb_sel = SEL_MEM; w_rwe = !w_mis; end
         OP_JAL, OP_JALR: begin       w_wb_sel = SEL_PC4; w_rwe = 1'b1; end
         default: begin               w_wb_sel = 2'b00;   w_rwe = 1'b0; end
      endcase
      case (funct3[1:0])
         2'b00: begin
            w_mask = 4'b0001 << addr[1:0];
            w_din  = {(XLEN/8){store_data[7:0]}};
         end
         2'b01: begin
            w_mask = 4'b0011 << {addr[1], 1'b0};
            w_din  = {(XLEN/16){store_data[15:0]}};
         end
         default: begin
            w_mask = 4'b1111;
            w_din  = store_data;
         end
      endcase
      // Duplicate CSR indices: only the lowest matching entry is written.
      w_csr_hit   = '0;
      w_csr_found = 1'b0;
      if ((opcode == OP_CSR) && (funct3[1:0] == 2'b01)) begin
         for (int unsigned i = 0; i < NUM_CSR; i++) begin
            if (!w_csr_found && (csr == CSR_ADDRS[12*i +: 12])) begin
               w_csr_hit[i] = 1'b1;
               w_csr_found  = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_is_load   <= 1'b0;
         r_is_store  <= 1'b0;
         r_mis       <= 1'b0;
         r_wb_sel    <= 2'b00;
         r_rwe       <= 1'b0;
         r_rd        <= '0;
         r_funct3    <= '0;
         r_addr      <= '0;
         r_din       <= '0;
         r_mask      <= '0;
         r_csr_wdata <= '0;
         r_csr_hit   <= '0;
         r_dout      <= '0;
         r_csr_q     <= '0;
      end else begin
         if (w_done) begin
            for (int unsigned i = 0; i < NUM_CSR; i++) begin
               if (r_csr_hit[i]) r_csr_q[XLEN*i +: XLEN] <= r_csr_wdata;
            end
         end
         case (r_state)
            ST_IDLE: if (w_capture) r_state <= ((w_is_load || w_is_store) && !w_mis) ? ST_MEM : ST_DONE;
            ST_MEM: begin
               if (!dcache_stall) begin
                  if (r_is_load) r_dout <= dcache_dout;
                  r_state <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (w_capture) r_state <= ((w_is_load || w_is_store) && !w_mis) ? ST_MEM : ST_DONE;
               else           r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
         if (w_capture) begin
            r_is_load   <= w_is_load;
            r_is_store  <= w_is_store;
            r_mis       <= w_mis;
            r_wb_sel    <= w_wb_sel;
            r_rwe       <= w_rwe;
            r_rd        <= rd;
            r_funct3    <= funct3;
            r_addr      <= addr;
            r_din       <= w_din;
            r_mask      <= w_mask;
            r_csr_wdata <= csr_wdata;
            r_csr_hit   <= w_csr_hit;
         end
      end
   end

   always_comb begin
      case (r_addr[1:0])
         2'd0:    w_byte = r_dout[7:0];
         2'd1:    w_byte = r_dout[15:8];
         2'd2:    w_byte = r_dout[23:16];
         default: w_byte = r_dout[31:24];
      endcase
      w_half = r_addr[1] ? r_dout[31:16] : r_dout[15:0];
      case (r_funct3)
         3'b000:  w_load = {{(XLEN-8){w_byte[7]}}, w_byte};
         3'b001:  w_load = {{(XLEN-16){w_half[15]}}, w_half};
         3'b100:  w_load = {{(XLEN-8){1'b0}}, w_byte};
         3'b101:  w_load = {{(XLEN-16){1'b0}}, w_half};
         default: w_load = r_dout;
      endcase
   end

   assign dcache_re   = (r_state == ST_MEM) && r_is_load;
   assign dcache_we   = ((r_state == ST_MEM) && r_is_store) ? r_mask : 4'b0000;
   assign dcache_addr = {r_addr[XLEN-1:2], 2'b00};
   assign dcache_din  = r_din;
   assign wb_valid    = w_done;
   assign wb_sel      = w_done ? r_wb_sel : 2'b00;
   assign rwe         = w_done && r_rwe;
   assign wb_rd       = w_done ? r_rd : 5'd0;
   assign misalign    = w_done && r_mis;
   assign load_data   = (w_done && r_is_load && !r_mis) ? w_load : '0;
   assign csr_we      = w_done ? r_csr_hit : '0;
   assign csr_q       = r_csr_q;

endmodule

// File: tb/tb_mw_ctrl_pipe.sv
// Bench for mw_ctrl_pipe: directed cases plus random instructions checked
// against a behavioural model of the memory/writeback rules.
module tb_mw_ctrl_pipe;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [11:0] csr;
   logic [4:0]  rd;
   logic [31:0] addr, store_data, csr_wdata;
   logic        dcache_re;
   logic [3:0]  dcache_we;
   logic [31:0] dcache_addr, dcache_din;
   logic        dcache_stall;
   logic [31:0] dcache_dout;
   logic        wb_valid;
   logic [1:0]  wb_sel;
   logic        rwe;
   logic [4:0]  wb_rd;
   logic [31:0] load_data;
   logic        misalign;
   logic [1:0]  csr_we;
   logic [63:0] csr_q;

   int passes = 0;
   int total  = 0;
   logic [31:0] csr_model [2];

   mw_ctrl_pipe #(.XLEN(32), .NUM_CSR(2), .CSR_ADDRS({12'h51F, 12'h51E})) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .opcode(opcode), .funct3(funct3), .csr(csr), .rd(rd), .addr(addr),
      .store_data(store_data), .csr_wdata(csr_wdata),
      .dcache_re(dcache_re), .dcache_we(dcache_we), .dcache_addr(dcache_addr),
      .dcache_din(dcache_din), .dcache_stall(dcache_stall), .dcache_dout(dcache_dout),
      .wb_valid(wb_valid), .wb_sel(wb_sel), .rwe(rwe), .wb_rd(wb_rd),
      .load_data(load_data), .misalign(misalign), .csr_we(csr_we), .csr_q(csr_q)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   function automatic logic [1:0] ref_sel(input logic [6:0] op);
      case (op)
         7'h73, 7'h17, 7'h37, 7'h33, 7'h13: return 2'b01;
         7'h03:                             return 2'b10;
         7'h6F, 7'h67:                      return 2'b11;
         default:                           return 2'b00;
      endcase
   endfunction

   task automatic scramble_inputs();
      opcode = 7'($urandom); funct3 = 3'($urandom); csr = 12'($urandom);
      rd = 5'($urandom); addr = $urandom; store_data = $urandom; csr_wdata = $urandom;
   endtask

   task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [11:0] c,
                            input logic [4:0] r, input logic [31:0] a, input logic [31:0] sd,
                            input logic [31:0] wd, input int stalls, input logic [31:0] dout);
      logic is_ld, is_st, mis, mem, exp_rwe;
      int size, off, idx;
      longint val;
      logic [3:0]  emask;
      logic [31:0] edin, eld;
      logic [1:0]  ecsr_we;
      is_ld = (op == 7'h03);
      is_st = (op == 7'h23);
      size  = 1 << f3[1:0];
      off   = int'(a[1:0]);
      mis   = (is_ld || is_st) && ((off % size) != 0);
      mem   = (is_ld || is_st) && !mis;
      emask = 4'(((1 << size) - 1) << off);
      for (int k = 0; k < 4; k++) edin[8*k +: 8] = sd[8*(k % size) +: 8];
      val = longint'(dout >> (8 * off));
      if (size < 4) begin
         val = val % (longint'(1) << (8 * size));
         if (!f3[2] && val >= (longint'(1) << (8 * size - 1))) val = val - (longint'(1) << (8 * size));
      end
      eld = 32'(val);
      exp_rwe = (op inside {7'h17, 7'h37, 7'h33, 7'h13, 7'h6F, 7'h67}) || (is_ld && !mis);
      idx = -1;
      if (op == 7'h73 && (f3 == 3'b001 || f3 == 3'b101)) begin
         if (c == 12'h51E) idx = 0;
         else if (c == 12'h51F) idx = 1;
      end
      ecsr_we = (idx < 0) ? 2'b00 : 2'(1 << idx);

      @(negedge clk);
      chk("ready_before_issue", 64'(in_ready), 64'(1));
      in_valid = 1'b1; opcode = op; funct3 = f3; csr = c; rd = r;
      addr = a; store_data = sd; csr_wdata = wd;
      @(posedge clk); #1;
      in_valid = 1'b0;
      scramble_inputs();
      if (mem) begin
         for (int k = 0; k <= stalls; k++) begin
            @(negedge clk);
            dcache_stall = (k < stalls);
            dcache_dout  = (k < stalls) ? $urandom : dout;
            chk("mem_re", 64'(dcache_re), 64'(is_ld));
            chk("mem_we", 64'(dcache_we), 64'(is_st ? emask : 4'b0000));
            chk("mem_addr", 64'(dcache_addr), 64'({a[31:2], 2'b00}));
            if (is_st) chk("mem_din", 64'(dcache_din), 64'(edin));
            chk("mem_ready", 64'(in_ready), 64'(0));
            chk("mem_wbvalid", 64'(wb_valid), 64'(0));
         end
      end
      @(negedge clk);
      dcache_stall = 1'($urandom);
      chk("done_wbvalid", 64'(wb_valid), 64'(1));
      chk("done_wbsel", 64'(wb_sel), 64'(ref_sel(op)));
      chk("done_rwe", 64'(rwe), 64'(exp_rwe));
      chk("done_wbrd", 64'(wb_rd), 64'(r));
      chk("done_misalign", 64'(misalign), 64'(mis));
      chk("done_csrwe", 64'(csr_we), 64'(ecsr_we));
      chk("done_re", 64'(dcache_re), 64'(0));
      chk("done_we", 64'(dcache_we), 64'(0));
      chk("done_ready", 64'(in_ready), 64'(1));
      if (is_ld && !mis) chk("done_loaddata", 64'(load_data), 64'(eld));
      if (idx >= 0) csr_model[idx] = wd;
      @(negedge clk);
      chk("idle_wbvalid", 64'(wb_valid), 64'(0));
      chk("idle_csrq", csr_q, {csr_model[1], csr_model[0]});
   endtask

   initial begin
      logic [6:0]  ops [11];
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [11:0] c;
      ops = '{7'h03, 7'h23, 7'h73, 7'h17, 7'h37, 7'h33, 7'h13, 7'h6F, 7'h67, 7'h63, 7'h00};
      csr_model[0] = '0; csr_model[1] = '0;
      reset = 1'b1; in_valid = 1'b0; dcache_stall = 1'b0; dcache_dout = '0;
      scramble_inputs();
      repeat (2) @(negedge clk);
      chk("rst_ready", 64'(in_ready), 64'(1));
      chk("rst_wbvalid", 64'(wb_valid), 64'(0));
      chk("rst_rwe", 64'(rwe), 64'(0));
      chk("rst_wbsel", 64'(wb_sel), 64'(0));
      chk("rst_wbrd", 64'(wb_rd), 64'(0));
      chk("rst_loaddata", 64'(load_data), 64'(0));
      chk("rst_misalign", 64'(misalign), 64'(0));
      chk("rst_re", 64'(dcache_re), 64'(0));
      chk("rst_we", 64'(dcache_we), 64'(0));
      chk("rst_csrwe", 64'(csr_we), 64'(0));
      chk("rst_csrq", csr_q, 64'(0));
      reset = 1'b0;

      // LB with two stall cycles, SH single-cycle, misaligned LW
      run_instr(7'h03, 3'b000, 12'h0, 5'd7, 32'h0000_1003, 32'h0, 32'h0, 2, 32'h80FF_FF11);
      run_instr(7'h23, 3'b001, 12'h0, 5'd0, 32'h0000_2002, 32'h0000_ABCD, 32'h0, 0, 32'h0);
      run_instr(7'h03, 3'b010, 12'h0, 5'd9, 32'h0000_3001, 32'h0, 32'h0, 0, 32'h0);
      // CSR writes: matching index, non-matching index, CSRRWI
      run_instr(7'h73, 3'b001, 12'h51F, 5'd1, 32'h0, 32'h0, 32'h0000_0001, 0, 32'h0);
      run_instr(7'h73, 3'b001, 12'h300, 5'd1, 32'h0, 32'h0, 32'hDEAD_BEEF, 0, 32'h0);
      run_instr(7'h73, 3'b101, 12'h51E, 5'd2, 32'h0, 32'h0, 32'h0000_0015, 0, 32'h0);

      // back-to-back ADDI, ADD, JAL
      @(negedge clk);
      in_valid = 1'b1; opcode = 7'h13; funct3 = 3'b000; rd = 5'd1; addr = 32'h11;
      @(negedge clk);
      chk("b2b0_wbvalid", 64'(wb_valid), 64'(1));
      chk("b2b0_wbsel", 64'(wb_sel), 64'(2'b01));
      chk("b2b0_rwe", 64'(rwe), 64'(1));
      chk("b2b0_wbrd", 64'(wb_rd), 64'(1));
      opcode = 7'h33; rd = 5'd2;
      @(negedge clk);
      chk("b2b1_wbvalid", 64'(wb_valid), 64'(1));
      chk("b2b1_wbsel", 64'(wb_sel), 64'(2'b01));
      chk("b2b1_rwe", 64'(rwe), 64'(1));
      chk("b2b1_wbrd", 64'(wb_rd), 64'(2));
      opcode = 7'h6F; rd = 5'd3;
      @(negedge clk);
      chk("b2b2_wbvalid", 64'(wb_valid), 64'(1));
      chk("b2b2_wbsel", 64'(wb_sel), 64'(2'b11));
      chk("b2b2_rwe", 64'(rwe), 64'(1));
      chk("b2b2_wbrd", 64'(wb_rd), 64'(3));
      in_valid = 1'b0;
      @(negedge clk);
      chk("b2b_end_wbvalid", 64'(wb_valid), 64'(0));

      // randomized instructions
      for (int n = 0; n < 80; n++) begin
         op = ops[$urandom_range(0, 10)];
         if (op == 7'h03)      f3 = 3'({1'($urandom), 2'($urandom_range(0, 1))} | ((($urandom & 3) == 0) ? 3'b010 : 3'b000)) & ((($urandom & 1) == 1) ? 3'b111 : 3'b011);
         else if (op == 7'h23) f3 = 3'($urandom_range(0, 2));
         else                  f3 = 3'($urandom);
         if (op == 7'h03 && f3[1:0] == 2'b11) f3 = 3'b010;
         if (op == 7'h03 && f3 == 3'b110) f3 = 3'b100;
         case ($urandom_range(0, 3))
            0: c = 12'h51E;
            1: c = 12'h51F;
            2: c = 12'h300;
            default: c = 12'($urandom);
         endcase
         run_instr(op, f3, c, 5'($urandom), $urandom, $urandom, $urandom,
                   $urandom_range(0, 3), $urandom);
      end

      // reset abandons a stalled load
      @(negedge clk);
      in_valid = 1'b1; opcode = 7'h03; funct3 = 3'b010; rd = 5'd4; addr = 32'h100;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      dcache_stall = 1'b1;
      chk("rstmem_re_before", 64'(dcache_re), 64'(1));
      reset = 1'b1;
      @(negedge clk);
      chk("rstmem_re", 64'(dcache_re), 64'(0));
      chk("rstmem_ready", 64'(in_ready), 64'(1));
      chk("rstmem_wbvalid", 64'(wb_valid), 64'(0));
      chk("rstmem_csrq", csr_q, 64'(0));
      csr_model[0] = '0; csr_model[1] = '0;
      reset = 1'b0; dcache_stall = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("rstmem_after_wbvalid", 64'(wb_valid), 64'(0));
         chk("rstmem_after_re", 64'(dcache_re), 64'(0));
         chk("rstmem_after_csrwe", 64'(csr_we), 64'(0));
      end

      // reset wins over a simultaneous capture
      in_valid = 1'b1; opcode = 7'h13; rd = 5'd5; reset = 1'b1;
      @(negedge clk);
      chk("rstcap_wbvalid", 64'(wb_valid), 64'(0));
      reset = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      chk("rstcap_after_wbvalid", 64'(wb_valid), 64'(0));

      run_instr(7'h03, 3'b101, 12'h0, 5'd6, 32'h0000_4002, 32'h0, 32'h0, 1, 32'h8001_7FFE);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
